// File: rtl/counter_timer_ctrl.sv
// Sequencing controller that turns an external synchronous up counter into a
// one-shot or periodic timer, pulsing done once per elapsed period.
module counter_timer_ctrl #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         stop,
   input  logic         hold,
   input  logic         mode,
   input  logic [N-1:0] period,
   input  logic [N-1:0] cnt_q,
   output logic         cnt_rst,
   output logic         cnt_en,
   output logic         busy,
   output logic         done,
   output logic         start_err,
   output logic         state_dbg
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t       state;
   logic [N-1:0] period_r;
   logic         mode_r;
   logic [N-1:0] period_m1;
   logic         tc;

   // period_r is never 0 while RUN, so this cannot underflow when it matters.
   assign period_m1 = period_r - N'(1);
   assign tc        = (state == RUN) && !hold && !stop && (cnt_q == period_m1);

   assign busy      = (state == RUN);
   assign cnt_en    = (state == RUN) && !hold;
   assign cnt_rst   = rst || (state != RUN) || (tc && mode_r);
   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         period_r  <= '0;
         mode_r    <= 1'b0;
         done      <= 1'b0;
         start_err <= 1'b0;
      end else begin
         done      <= 1'b0;
         start_err <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (period != '0) begin
                     period_r <= period;
                     mode_r   <= mode;
                     state    <= RUN;
                  end else begin
                     start_err <= 1'b1;
                  end
               end
            end
            RUN: begin
               // stop outranks terminal count: an aborted timer never reports done.
               if (stop) begin
                  state <= IDLE;
               end else if (tc) begin
                  done <= 1'b1;
                  if (!mode_r) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// Directed bench for counter_timer_ctrl driving a behavioural up counter.
module tb_counter_timer_ctrl;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         stop;
   logic         hold;
   logic         mode;
   logic [N-1:0] period;
   logic [N-1:0] cnt_q;
   logic         cnt_rst;
   logic         cnt_en;
   logic         busy;
   logic         done;
   logic         start_err;
   logic         state_dbg;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   counter_timer_ctrl #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .hold      (hold),
      .mode      (mode),
      .period    (period),
      .cnt_q     (cnt_q),
      .cnt_rst   (cnt_rst),
      .cnt_en    (cnt_en),
      .busy      (busy),
      .done      (done),
      .start_err (start_err),
      .state_dbg (state_dbg)
   );

   // Environment model of the N-bit up counter with synchronous reset.
   always_ff @(posedge clk) begin
      if (cnt_rst)     cnt_q <= '0;
      else if (cnt_en) cnt_q <= cnt_q + N'(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [N-1:0] p, input logic m);
      period = p;
      mode   = m;
      start  = 1'b1;
      tick();
      start  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0; mode = 1'b0; period = '0;
      tick(); tick(); tick();
      rst = 1'b0;
      #1;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
      checks++;
      if (start_err !== 1'b0) begin errors++; $display("FAIL reset_start_err got=%0b exp=0", start_err); end
      checks++;
      if (cnt_rst !== 1'b1) begin errors++; $display("FAIL reset_cnt_rst got=%0b exp=1", cnt_rst); end
      checks++;
      if (cnt_en !== 1'b0) begin errors++; $display("FAIL reset_cnt_en got=%0b exp=0", cnt_en); end
      checks++;
      if (cnt_q !== 8'd0) begin errors++; $display("FAIL reset_cnt_q got=%0d exp=0", cnt_q); end
      checks++;
      if (state_dbg !== 1'b0) begin errors++; $display("FAIL reset_state got=%0b exp=0", state_dbg); end
      checks++;
      tick();
   endtask

   task automatic test_oneshot();
      launch(8'd5, 1'b0);
      if (busy !== 1'b1 || cnt_q !== 8'd0) begin
         errors++; $display("FAIL oneshot_start busy=%0b cnt=%0d exp busy=1 cnt=0", busy, cnt_q);
      end
      checks++;
      for (int i = 1; i <= 4; i++) begin
         tick();
         if (cnt_q !== 8'(i) || done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_c%0d cnt=%0d done=%0b busy=%0b exp cnt=%0d done=0 busy=1", i, cnt_q, done, busy, i);
         end
         checks++;
      end
      tick();
      if (done !== 1'b1 || busy !== 1'b0 || cnt_q !== 8'd5) begin
         errors++; $display("FAIL oneshot_done done=%0b busy=%0b cnt=%0d exp done=1 busy=0 cnt=5", done, busy, cnt_q);
      end
      checks++;
      tick();
      if (done !== 1'b0 || cnt_q !== 8'd0) begin
         errors++; $display("FAIL oneshot_after done=%0b cnt=%0d exp done=0 cnt=0", done, cnt_q);
      end
      checks++;
   endtask

   task automatic test_periodic();
      launch(8'd3, 1'b1);
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (cnt_q !== 8'(c % 3) || done !== (c % 3 == 0) || busy !== 1'b1) begin
            errors++;
            $display("FAIL periodic_c%0d cnt=%0d done=%0b busy=%0b exp cnt=%0d done=%0b busy=1", c, cnt_q, done, busy, c % 3, c % 3 == 0);
         end
         checks++;
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL periodic_stop%0d done=%0b busy=%0b exp 0 0", c, done, busy);
         end
         checks++;
         tick();
      end
   endtask

   task automatic test_hold();
      launch(8'd4, 1'b0);
      tick(); tick();
      hold = 1'b1;
      #1;
      if (cnt_en !== 1'b0) begin errors++; $display("FAIL hold_cnt_en got=%0b exp=0", cnt_en); end
      checks++;
      for (int c = 3; c <= 4; c++) begin
         tick();
         if (cnt_q !== 8'd2 || done !== 1'b0) begin
            errors++; $display("FAIL hold_c%0d cnt=%0d done=%0b exp cnt=2 done=0", c, cnt_q, done);
         end
         checks++;
      end
      hold = 1'b0;
      tick();
      if (cnt_q !== 8'd3 || done !== 1'b0) begin
         errors++; $display("FAIL hold_c5 cnt=%0d done=%0b exp cnt=3 done=0", cnt_q, done);
      end
      checks++;
      tick();
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL hold_done done=%0b busy=%0b exp done=1 busy=0", done, busy);
      end
      checks++;
      tick();
   endtask

   task automatic test_illegal_start();
      launch(8'd0, 1'b0);
      if (start_err !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL illegal_err start_err=%0b busy=%0b exp 1 0", start_err, busy);
      end
      checks++;
      tick();
      if (start_err !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL illegal_after start_err=%0b busy=%0b exp 0 0", start_err, busy);
      end
      checks++;
      launch(8'd4, 1'b0);
      tick();
      start = 1'b1; period = 8'd2; mode = 1'b1;
      tick();
      if (cnt_q !== 8'd2 || start_err !== 1'b0) begin
         errors++; $display("FAIL ignored_c2 cnt=%0d start_err=%0b exp cnt=2 start_err=0", cnt_q, start_err);
      end
      checks++;
      tick();
      start = 1'b0;
      if (cnt_q !== 8'd3 || done !== 1'b0) begin
         errors++; $display("FAIL ignored_c3 cnt=%0d done=%0b exp cnt=3 done=0", cnt_q, done);
      end
      checks++;
      tick();
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL ignored_done done=%0b busy=%0b exp done=1 busy=0", done, busy);
      end
      checks++;
      tick();
   endtask

   task automatic test_p1();
      launch(8'd1, 1'b1);
      if (done !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL p1_start done=%0b busy=%0b exp 0 1", done, busy);
      end
      checks++;
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (done !== 1'b1 || cnt_q !== 8'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL p1_c%0d done=%0b cnt=%0d busy=%0b exp 1 0 1", c, done, cnt_q, busy);
         end
         checks++;
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL p1_stop done=%0b busy=%0b exp 0 0", done, busy);
      end
      checks++;
      tick();
   endtask

   task automatic test_stop_on_tc();
      launch(8'd3, 1'b1);
      tick(); tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL stop_tc done=%0b busy=%0b exp 0 0", done, busy);
      end
      checks++;
      tick();
   endtask

   task automatic test_back_to_back();
      launch(8'd2, 1'b0);
      tick(); tick();
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL b2b_done1 done=%0b busy=%0b exp 1 0", done, busy);
      end
      checks++;
      launch(8'd3, 1'b0);
      if (busy !== 1'b1 || cnt_q !== 8'd0 || done !== 1'b0) begin
         errors++; $display("FAIL b2b_restart busy=%0b cnt=%0d done=%0b exp 1 0 0", busy, cnt_q, done);
      end
      checks++;
      tick(); tick();
      if (cnt_q !== 8'd2 || done !== 1'b0) begin
         errors++; $display("FAIL b2b_c2 cnt=%0d done=%0b exp 2 0", cnt_q, done);
      end
      checks++;
      tick();
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL b2b_done2 done=%0b busy=%0b exp 1 0", done, busy);
      end
      checks++;
      tick();
   endtask

   task automatic test_reset_mid_run();
      launch(8'd6, 1'b1);
      tick(); tick(); tick();
      if (cnt_q !== 8'd3) begin errors++; $display("FAIL rstmid_pre cnt=%0d exp 3", cnt_q); end
      checks++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      if (busy !== 1'b0 || cnt_q !== 8'd0 || done !== 1'b0 || cnt_rst !== 1'b1 || cnt_en !== 1'b0) begin
         errors++;
         $display("FAIL rstmid busy=%0b cnt=%0d done=%0b cnt_rst=%0b cnt_en=%0b exp 0 0 0 1 0", busy, cnt_q, done, cnt_rst, cnt_en);
      end
      checks++;
      tick();
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_periodic();
      test_hold();
      test_illegal_start();
      test_p1();
      test_stop_on_tc();
      test_back_to_back();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
